pixel_max_buffer: RTL and testbench

Frame-capture stage directly upstream of the normalizer. It accepts one cropped frame of OUT_ROWS×OUT_COLS 8-bit pixels on an AXI-Stream slave, stores it in on-chip RAM and tracks the frame's maximum pixel. When capture completes it presents that maximum as `norm_denominator`, pulses `ap_done`, then replays the stored frame unchanged on an AXI-Stream master with `tlast` on the final pixel.

---
 rtl/pmb_pkg.sv | 23 ++
 rtl/pixel_max_buffer_if.sv | 13 +
 rtl/pixel_frame_ram.sv | 37 +++
 rtl/pixel_max_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_pixel_max_buffer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pmb_pkg.sv
// Shared definitions for the pixel max buffer: controller states, frame-size
// helpers and the default pixel width.
package pmb_pkg;

    localparam int PMB_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_REPLAY  = 2'd2
    } pmb_state_t;

    // Number of pixels in one frame.
    function automatic int pmb_frame_size(input int rows, input int cols);
        return rows * cols;
    endfunction

    // Address width for a RAM of the given depth (at least one bit).
    function automatic int pmb_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pixel_max_buffer_if.sv
// AXI-Stream style pixel channel. The master side drives valid/data/last, the
// slave side drives ready.
interface pixel_max_buffer_if #(
    parameter int DATA_WIDTH = pmb_pkg::PMB_DATA_WIDTH
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/pixel_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// Written to map onto block or distributed RAM.
module pixel_frame_ram #(
    parameter int DEPTH      = 100,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Write port.
    // NOTE: the array has no reset so it can infer RAM; a reset loop would force flops.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pixel_max_buffer.sv
// Frame capture stage ahead of the normalizer: stores one frame, tracks its
// maximum pixel, reports it on norm_denominator and replays the frame.
// Optional build macro PMB_ZERO_GUARD_EN: a frame maximum of 0 is reported
// as 1 so the downstream reciprocal LUT is never indexed at 0.
module pixel_max_buffer
    import pmb_pkg::*;
#(
    parameter int OUT_ROWS   = 10,
    parameter int OUT_COLS   = 10,
    parameter int DATA_WIDTH = PMB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    pixel_max_buffer_if.slave     s_axis,
    pixel_max_buffer_if.master    m_axis,
    output logic [DATA_WIDTH-1:0] norm_denominator
);

    localparam int            N         = pmb_frame_size(OUT_ROWS, OUT_COLS);
    localparam int            AW        = pmb_addr_width(N);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    pmb_state_t r_state;
    pmb_state_t w_state_next;

    logic                  w_start;
    logic                  w_s_tready;
    logic                  w_s_hs;
    logic                  w_wr_last;
    logic [DATA_WIDTH-1:0] w_max_cand;
    logic [DATA_WIDTH-1:0] w_denom_next;

    logic [AW-1:0]         r_wr_cnt;
    logic [DATA_WIDTH-1:0] r_run_max;
    logic [DATA_WIDTH-1:0] r_norm_denom;
    logic                  r_done;

    logic [AW-1:0]         r_rd_cnt;
    logic                  r_rd_all;
    logic                  r_rd_pend;
    logic                  r_pend_last;
    logic                  w_rd_en;
    logic [2:0]            w_occ_next;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    logic [DATA_WIDTH-1:0] r_skid_data [2];
    logic [1:0]            r_skid_last;
    logic                  r_skid_wp;
    logic                  r_skid_rp;
    logic [1:0]            r_skid_cnt;
    logic                  w_m_valid;
    logic                  w_m_hs;
    logic                  w_tx_last;

    // Capture-side handshake and the candidate maximum including this pixel.
    assign w_s_hs     = w_s_tready & s_axis.tvalid;
    assign w_wr_last  = w_s_hs & (r_wr_cnt == LAST_ADDR);
    assign w_max_cand = (s_axis.tdata > r_run_max) ? s_axis.tdata : r_run_max;

`ifdef PMB_ZERO_GUARD_EN
    assign w_denom_next = (w_max_cand == '0) ? DATA_WIDTH'(1) : w_max_cand;
`else
    assign w_denom_next = w_max_cand;
`endif

    // Replay-side handshake; the skid slot at the read pointer is the output.
    assign w_m_valid = (r_skid_cnt != 2'd0);
    assign w_m_hs    = w_m_valid & m_axis.tready;
    assign w_tx_last = w_m_hs & r_skid_last[r_skid_rp];

    // Issue a RAM read only if the skid buffer can still absorb it next cycle.
    // The first read goes out alongside the final capture beat so replay data
    // appears two cycles after that beat.
    assign w_occ_next = {1'b0, r_skid_cnt} + {2'b00, r_rd_pend} - {2'b00, w_m_hs};
    assign w_rd_en    = ((r_state == ST_REPLAY) | w_wr_last) & ~r_rd_all
                        & (w_occ_next < 3'd2);

    pixel_frame_ram #(
        .DEPTH      (N),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_frame_ram (
        .clk     (clk),
        .i_we    (w_s_hs),
        .i_waddr (r_wr_cnt),
        .i_wdata (s_axis.tdata),
        .i_re    (w_rd_en),
        .i_raddr (r_rd_cnt),
        .o_rdata (w_ram_rdata)
    );

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-dependent control outputs.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_s_tready   = 1'b0;
        ap_ready     = 1'b0;
        ap_idle      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ap_ready = 1'b1;
                ap_idle  = 1'b1;
                if (ap_start) begin
                    w_start      = 1'b1;
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_s_tready = 1'b1;
                if (w_wr_last) begin
                    w_state_next = ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                if (w_tx_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Capture: write counter, running maximum, reported maximum and done pulse.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_wr_cnt     <= '0;
            r_run_max    <= '0;
            r_norm_denom <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_wr_last;
            if (w_start) begin
                r_wr_cnt  <= '0;
                r_run_max <= '0;
            end else if (w_s_hs) begin
                r_run_max <= w_max_cand;
                if (!w_wr_last) begin
                    r_wr_cnt <= r_wr_cnt + ADDR_ONE;
                end
            end
            if (w_wr_last) begin
                r_norm_denom <= w_denom_next;
            end
        end
    end

    // Replay read sequencing: address counter and the in-flight read tag.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_rd_cnt    <= '0;
            r_rd_all    <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_rd_pend   <= w_rd_en;
            r_pend_last <= w_rd_en & (r_rd_cnt == LAST_ADDR);
            if (w_start) begin
                r_rd_cnt <= '0;
                r_rd_all <= 1'b0;
            end else if (w_rd_en) begin
                if (r_rd_cnt == LAST_ADDR) begin
                    r_rd_all <= 1'b1;
                end else begin
                    r_rd_cnt <= r_rd_cnt + ADDR_ONE;
                end
            end
        end
    end

    // Two-entry output skid buffer fed by RAM read data.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            for (int i = 0; i < 2; i++) begin
                r_skid_data[i] <= '0;
            end
            r_skid_last <= '0;
            r_skid_wp   <= 1'b0;
            r_skid_rp   <= 1'b0;
            r_skid_cnt  <= '0;
        end else begin
            if (r_rd_pend) begin
                r_skid_data[r_skid_wp] <= w_ram_rdata;
                r_skid_last[r_skid_wp] <= r_pend_last;
                r_skid_wp              <= ~r_skid_wp;
            end
            if (w_m_hs) begin
                r_skid_rp <= ~r_skid_rp;
            end
            r_skid_cnt <= r_skid_cnt + {1'b0, r_rd_pend} - {1'b0, w_m_hs};
        end
    end

    assign s_axis.tready    = w_s_tready;
    assign m_axis.tvalid    = w_m_valid;
    assign m_axis.tdata     = r_skid_data[r_skid_rp];
    assign m_axis.tlast     = r_skid_last[r_skid_rp];
    assign ap_done          = r_done;
    assign norm_denominator = r_norm_denom;

endmodule

// File: tb/tb_pixel_max_buffer.sv
// Self-checking bench for pixel_max_buffer. The reference model is the input
// frame itself: replay must reproduce it in order and the reported maximum is
// computed directly from the frame contents.
module tb_pixel_max_buffer;

    localparam int ROWS   = 10;
    localparam int COLS   = 10;
    localparam int N      = ROWS * COLS;
    localparam int DW     = 8;
    localparam int BUDGET = 5000;

    logic          clk = 1'b0;
    logic          srst;
    logic          ap_start;
    logic          ap_ready;
    logic          ap_idle;
    logic          ap_done;
    logic [DW-1:0] norm_denominator;

    pixel_max_buffer_if #(.DATA_WIDTH(DW)) s_if ();
    pixel_max_buffer_if #(.DATA_WIDTH(DW)) m_if ();

    pixel_max_buffer #(
        .OUT_ROWS   (ROWS),
        .OUT_COLS   (COLS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk              (clk),
        .srst             (srst),
        .ap_start         (ap_start),
        .ap_ready         (ap_ready),
        .ap_idle          (ap_idle),
        .ap_done          (ap_done),
        .s_axis           (s_if),
        .m_axis           (m_if),
        .norm_denominator (norm_denominator)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] frame_q[$];
    logic [DW-1:0] prev_denom;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reported maximum for the current frame.
    function automatic logic [DW-1:0] expected_denom();
        logic [DW-1:0] mx = '0;
        foreach (frame_q[i]) begin
            if (frame_q[i] > mx) mx = frame_q[i];
        end
`ifdef PMB_ZERO_GUARD_EN
        if (mx == '0) mx = 1;
`endif
        return mx;
    endfunction

    function automatic void fill_random();
        frame_q = {};
        for (int i = 0; i < N; i++) frame_q.push_back(DW'($urandom_range(255)));
    endfunction

    // Runs one frame from IDLE. Called at a sampling point (#1 after an edge).
    // vprob/rprob: percent chance of s_tvalid / m_tready per cycle.
    // noise: random ap_start pulses while busy. abort_beat >= 0: reset after
    // that many replay beats were accepted.
    task automatic run_frame(input int vprob, input int rprob, input bit noise, input int abort_beat);
        int            in_idx    = 0;
        int            out_idx   = 0;
        int            cyc       = 0;
        int            hs_last   = -1;
        int            first_v   = -1;
        int            last_out  = -1;
        int            done_cnt  = 0;
        bit            finished  = 0;
        bit            aborted   = 0;
        bit            stall     = 0;
        bit            s_hs;
        bit            m_hs;
        logic [DW-1:0] stall_d   = '0;
        logic          stall_l   = 1'b0;
        logic [DW-1:0] exp_denom = expected_denom();

        check("idle_before_start", ap_idle, 1);
        check("ready_before_start", ap_ready, 1);
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        check("tready_after_start", s_if.tready, 1);
        check("idle_low_in_capture", ap_idle, 0);

        while (!finished && cyc < BUDGET) begin
            if (ap_done) begin
                done_cnt++;
                check("done_timing", cyc, hs_last + 1);
            end
            check("denom", norm_denominator, (done_cnt > 0) ? exp_denom : prev_denom);
            if (stall) begin
                check("stall_valid", m_if.tvalid, 1);
                check("stall_data", m_if.tdata, stall_d);
                check("stall_last", m_if.tlast, stall_l);
            end
            if (m_if.tvalid && first_v < 0) begin
                first_v = cyc;
                check("first_valid_latency", cyc, hs_last + 2);
            end

            s_if.tvalid = (in_idx < N) && ($urandom_range(99) < vprob);
            s_if.tdata  = (in_idx < N) ? frame_q[in_idx] : '0;
            m_if.tready = ($urandom_range(99) < rprob);
            ap_start    = noise && ($urandom_range(7) == 0);

            s_hs = s_if.tvalid && s_if.tready;
            m_hs = m_if.tvalid && m_if.tready;
            if (s_hs) begin
                in_idx++;
                if (in_idx == N) hs_last = cyc;
            end
            if (m_hs) begin
                check("data", m_if.tdata, frame_q[out_idx]);
                check("tlast", m_if.tlast, out_idx == N - 1);
                out_idx++;
                if (out_idx == N) begin
                    finished = 1;
                    last_out = cyc;
                end
            end
            stall   = m_if.tvalid && !m_if.tready;
            stall_d = m_if.tdata;
            stall_l = m_if.tlast;

            if (abort_beat >= 0 && out_idx == abort_beat) begin
                aborted  = 1;
                finished = 1;
            end else begin
                step();
                cyc++;
            end
        end

        ap_start    = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;

        if (aborted) begin
            srst = 1'b1;
            #1;
            check("rst_tvalid", m_if.tvalid, 0);
            check("rst_tlast", m_if.tlast, 0);
            check("rst_idle", ap_idle, 1);
            check("rst_ready", ap_ready, 1);
            check("rst_done", ap_done, 0);
            check("rst_s_tready", s_if.tready, 0);
            check("rst_denom", norm_denominator, 0);
            step();
            step();
            srst = 1'b0;
            prev_denom = '0;
        end else begin
            check("frame_complete", out_idx, N);
            check("done_count", done_cnt, 1);
            check("idle_after_tlast", ap_idle, 1);
            check("ready_after_tlast", ap_ready, 1);
            check("tvalid_after_tlast", m_if.tvalid, 0);
            if (rprob >= 100) begin
                check("consecutive_beats", last_out - first_v, N - 1);
            end
            prev_denom = exp_denom;
        end
    endtask

    initial begin
        srst        = 1'b1;
        ap_start    = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        prev_denom  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_idle", ap_idle, 1);
        check("reset_ready", ap_ready, 1);
        check("reset_done", ap_done, 0);
        check("reset_s_tready", s_if.tready, 0);
        check("reset_m_tvalid", m_if.tvalid, 0);
        check("reset_m_tdata", m_if.tdata, 0);
        check("reset_m_tlast", m_if.tlast, 0);
        check("reset_denom", norm_denominator, 0);
        srst = 1'b0;
        step();

        // Ramp 0..N-1 at full rate.
        frame_q = {};
        for (int i = 0; i < N; i++) frame_q.push_back(DW'(i));
        run_frame(100, 100, 0, -1);

        // Flat frame with a single peak at index 57.
        frame_q = {};
        for (int i = 0; i < N; i++) frame_q.push_back((i == 57) ? 8'hF3 : 8'h17);
        run_frame(100, 100, 0, -1);

        // All-zero frame exercises the zero guard.
        frame_q = {};
        for (int i = 0; i < N; i++) frame_q.push_back(8'h00);
        run_frame(100, 100, 0, -1);

        // Random frames with gaps on both sides and stray ap_start pulses.
        for (int k = 0; k < 3; k++) begin
            fill_random();
            run_frame(60, 50, 1, -1);
        end

        // Reset mid-replay, then a complete frame.
        fill_random();
        run_frame(70, 60, 1, 40);
        fill_random();
        run_frame(80, 70, 0, -1);

        // Back-to-back: high maximum followed by a lower one.
        frame_q = {};
        for (int i = 0; i < N; i++) frame_q.push_back((i == 10) ? 8'hA0 : DW'($urandom_range(64)));
        run_frame(100, 100, 0, -1);
        frame_q = {};
        for (int i = 0; i < N; i++) frame_q.push_back((i == 80) ? 8'h30 : DW'($urandom_range(32)));
        run_frame(100, 100, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
